// File: rtl/pc_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer_pkg
//  Description : Shared types and helpers for the fetch PC sequencer
//                (state encoding, PC increment, redirect-target legality).
//  Revision    : 1.0 - initial release
// ============================================================================
package pc_sequencer_pkg;

    // Sequencer states; explicit 2-bit encoding
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } pcseq_state_e;

    // Byte distance between consecutive instruction words
    localparam int PC_INC = 4;

    // A redirect target is legal when it is word aligned and addressable
    // by a PC of pc_w bits (no bits set above the PC width).
    function automatic logic target_legal(input logic [31:0] target,
                                          input int unsigned pc_w);
        return (target[1:0] == 2'b00) && ((target >> pc_w) == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Fetch PC register and sequencer. Handles sequential +4,
//                branch/jal redirects, halt, stall, bad-target fault and
//                restart; drives pipeline squash and a redirect counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int PC_W     = 9,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic             ex_pc_sel,
    input  logic             ex_halt,
    input  logic [31:0]      ex_br_pc,
    input  logic             stall,
    input  logic             restart,
    output logic [PC_W-1:0]  pc_q,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [PC_W-1:0]  C_RESET_PC = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0]  C_PC_INC   = PC_W'(PC_INC);
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    pcseq_state_e     r_state;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_redirect_cnt;
    logic             r_halted;
    logic             r_fault;

    logic w_take;
    logic w_halt_ev;
    logic w_bad;
    logic w_flush;

    // Resolve-stage decode; a halt is never treated as a bad redirect
    always_comb begin
        w_take    = ex_valid & ex_pc_sel;
        w_halt_ev = ex_valid & ex_halt;
        w_bad     = w_take & ~ex_halt & ~target_legal(ex_br_pc, PC_W);
    end

    // Squash both younger stages on any redirect and continuously while parked
    always_comb begin
        w_flush = 1'b0;
        if (r_state != RUN) begin
            w_flush = 1'b1;
        end else begin
            w_flush = w_halt_ev | w_take;
        end
    end

    // Sequencer FSM, PC register, status flags and saturating redirect counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= RUN;
            r_pc           <= C_RESET_PC;
            r_redirect_cnt <= '0;
            r_halted       <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_halt_ev) begin
                        r_pc     <= ex_br_pc[PC_W-1:0];
                        r_state  <= HALT;
                        r_halted <= 1'b1;
                    end else if (w_bad) begin
                        r_state <= FAULT;
                        r_fault <= 1'b1;
                    end else if (w_take) begin
                        r_pc <= ex_br_pc[PC_W-1:0];
                        if (r_redirect_cnt != C_CNT_MAX) begin
                            r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
                        end
                    end else if (!stall) begin
                        r_pc <= r_pc + C_PC_INC;
                    end
                end
                HALT, FAULT: begin
                    if (restart) begin
                        r_pc     <= C_RESET_PC;
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                        r_fault  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                    r_fault  <= 1'b0;
                end
            endcase
        end
    end

    assign pc_q         = r_pc;
    assign flush_if_id  = w_flush;
    assign flush_id_ex  = w_flush;
    assign halted       = r_halted;
    assign fault        = r_fault;
    assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Directed, table-driven self-checking bench for pc_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        ex_valid;
    logic        ex_pc_sel;
    logic        ex_halt;
    logic [31:0] ex_br_pc;
    logic        stall;
    logic        restart;
    logic [8:0]  pc_q;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        halted;
    logic        fault;
    logic [15:0] redirect_cnt;

    int errors = 0;
    int checks = 0;

    pc_sequencer #(
        .PC_W     (9),
        .RESET_PC (0),
        .CNT_W    (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_pc_sel    (ex_pc_sel),
        .ex_halt      (ex_halt),
        .ex_br_pc     (ex_br_pc),
        .stall        (stall),
        .restart      (restart),
        .pc_q         (pc_q),
        .flush_if_id  (flush_if_id),
        .flush_id_ex  (flush_id_ex),
        .halted       (halted),
        .fault        (fault),
        .redirect_cnt (redirect_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One stimulus cycle: inputs, flush expected before the edge, state after it
    typedef struct {
        logic        rst;
        logic        valid;
        logic        sel;
        logic        halt;
        logic [31:0] br;
        logic        stl;
        logic        rstart;
        logic        exp_flush;
        logic [8:0]  exp_pc;
        logic        exp_halted;
        logic        exp_fault;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic s, input logic h,
                         input logic [31:0] b, input logic st, input logic rs);
        reset     = r;
        ex_valid  = v;
        ex_pc_sel = s;
        ex_halt   = h;
        ex_br_pc  = b;
        stall     = st;
        restart   = rs;
    endtask

    task automatic add(input logic r, input logic v, input logic s, input logic h,
                       input logic [31:0] b, input logic st, input logic rs,
                       input logic ef, input logic [8:0] ep, input logic eh,
                       input logic efa, input logic [15:0] ec);
        vec_t t;
        t.rst = r; t.valid = v; t.sel = s; t.halt = h; t.br = b; t.stl = st;
        t.rstart = rs; t.exp_flush = ef; t.exp_pc = ep; t.exp_halted = eh;
        t.exp_fault = efa; t.exp_cnt = ec;
        vecs.push_back(t);
    endtask

    // Apply one cycle and check flush before the edge, state after it
    task automatic step(input vec_t t, input string tag);
        @(negedge clk);
        drive(t.rst, t.valid, t.sel, t.halt, t.br, t.stl, t.rstart);
        #1;
        check({tag, " flush_if_id"}, {31'd0, flush_if_id}, {31'd0, t.exp_flush});
        check({tag, " flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, t.exp_flush});
        @(posedge clk);
        #1;
        check({tag, " pc_q"},   {23'd0, pc_q},         {23'd0, t.exp_pc});
        check({tag, " halted"}, {31'd0, halted},       {31'd0, t.exp_halted});
        check({tag, " fault"},  {31'd0, fault},        {31'd0, t.exp_fault});
        check({tag, " cnt"},    {16'd0, redirect_cnt}, {16'd0, t.exp_cnt});
    endtask

    initial begin
        vec_t t;

        // rst valid sel halt br stall restart | flush pc halted fault cnt
        // idle sequential fetch
        add(0,0,0,0,32'h0,  0,0, 0,9'h004,0,0,16'd0);
        add(0,0,0,0,32'h0,  0,0, 0,9'h008,0,0,16'd0);
        add(0,0,0,0,32'h0,  0,0, 0,9'h00C,0,0,16'd0);
        add(0,0,0,0,32'h0,  0,0, 0,9'h010,0,0,16'd0);
        // taken branch beats stall
        add(0,1,1,0,32'h40, 1,0, 1,9'h040,0,0,16'd1);
        // plain stall holds pc, no flush
        add(0,0,0,0,32'h0,  1,0, 0,9'h040,0,0,16'd1);
        add(0,0,0,0,32'h0,  0,0, 0,9'h044,0,0,16'd1);
        // halt without pc_sel
        add(0,1,0,1,32'h24, 0,0, 1,9'h024,1,0,16'd1);
        // parked in HALT: ex_* and stall ignored, flush held
        add(0,1,1,0,32'h80, 0,0, 1,9'h024,1,0,16'd1);
        add(0,1,1,0,32'h80, 1,0, 1,9'h024,1,0,16'd1);
        add(0,1,1,1,32'h88, 0,0, 1,9'h024,1,0,16'd1);
        // restart out of HALT, flush still 1 that cycle
        add(0,0,0,0,32'h0,  0,1, 1,9'h000,0,0,16'd1);
        // restart in RUN is ignored
        add(0,0,0,0,32'h0,  0,1, 0,9'h004,0,0,16'd1);
        // misaligned target -> FAULT, pc and counter held
        add(0,1,1,0,32'h42, 0,0, 1,9'h004,0,1,16'd1);
        add(0,1,0,1,32'h10, 0,0, 1,9'h004,0,1,16'd1);
        add(0,0,0,0,32'h0,  0,1, 1,9'h000,0,0,16'd1);
        // out-of-range target -> FAULT
        add(0,1,1,0,32'h400,0,0, 1,9'h000,0,1,16'd1);
        add(0,0,0,0,32'h0,  0,1, 1,9'h000,0,0,16'd1);
        // legal high target
        add(0,1,1,0,32'h100,0,0, 1,9'h100,0,0,16'd2);
        // valid but not selected: sequential
        add(0,1,0,0,32'h80, 0,0, 0,9'h104,0,0,16'd2);
        // selected but not valid: gated off
        add(0,0,1,0,32'h80, 0,0, 0,9'h108,0,0,16'd2);
        // halt wins over an illegal target; pc takes low PC_W bits
        add(0,1,1,1,32'h431,0,0, 1,9'h031,1,0,16'd2);
        // reset while halted
        add(1,0,0,0,32'h0,  0,0, 1,9'h000,0,0,16'd0);
        add(0,1,1,0,32'h60, 0,0, 1,9'h060,0,0,16'd1);
        // reset in a redirect cycle
        add(1,1,1,0,32'h80, 0,0, 1,9'h000,0,0,16'd0);
        add(0,0,0,0,32'h0,  0,0, 0,9'h004,0,0,16'd0);
        // redirect near the top, then wrap
        add(0,1,1,0,32'h1F8,0,0, 1,9'h1F8,0,0,16'd1);
        add(0,0,0,0,32'h0,  0,0, 0,9'h1FC,0,0,16'd1);
        add(0,0,0,0,32'h0,  0,0, 0,9'h000,0,0,16'd1);

        // reset state
        drive(1, 0, 0, 0, 32'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("reset pc_q",   {23'd0, pc_q},         32'd0);
        check("reset halted", {31'd0, halted},       32'd0);
        check("reset fault",  {31'd0, fault},        32'd0);
        check("reset cnt",    {16'd0, redirect_cnt}, 32'd0);
        check("reset flush",  {31'd0, flush_if_id},  32'd0);

        foreach (vecs[i]) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // counter saturation: preload all-ones, then one more taken redirect
        @(negedge clk);
        drive(0, 0, 0, 0, 32'h0, 0, 0);
        force dut.r_redirect_cnt = 16'hFFFF;
        #1;
        release dut.r_redirect_cnt;
        t = '{rst:0, valid:1, sel:1, halt:0, br:32'h20, stl:0, rstart:0,
              exp_flush:1, exp_pc:9'h020, exp_halted:0, exp_fault:0, exp_cnt:16'hFFFF};
        step(t, "sat1");
        t = '{rst:0, valid:1, sel:1, halt:0, br:32'h28, stl:1, rstart:0,
              exp_flush:1, exp_pc:9'h028, exp_halted:0, exp_fault:0, exp_cnt:16'hFFFF};
        step(t, "sat2");
        t = '{rst:0, valid:0, sel:0, halt:0, br:32'h0, stl:0, rstart:0,
              exp_flush:0, exp_pc:9'h02C, exp_halted:0, exp_fault:0, exp_cnt:16'hFFFF};
        step(t, "sat3");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the bench always terminates
    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: got no finish expected finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
